// File: rtl/rv_ctrl_pkg.sv
// Shared control-path definitions: redirect FSM state encoding and default address width.
package rv_ctrl_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } redir_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-low clear.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/redirect_ctrl.sv
// Branch/jump redirect controller: IDLE -> REQ (offer redirect, flush, stall) -> DRAIN -> IDLE.
// Optional saturating perf counters are built only when REDIRECT_PERF_EN is defined.
module redirect_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              jump_flag,
   input  logic [XLEN-1:0]   jump_target,
   input  logic              fetch_ready,
   output logic              redir_valid,
   output logic [XLEN-1:0]   redir_pc,
   output logic              flush_if,
   output logic              flush_id,
   output logic              stall_ex,
   output logic [PERF_W-1:0] jump_count,
   output logic [PERF_W-1:0] stall_count,
   output redir_state_e      state_dbg
);

   // Fetch handshake: redir_valid/redir_pc are offered in REQ and held stable until
   // a cycle where fetch_ready=1 is sampled with redir_valid=1; that cycle is the transfer.

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);

   redir_state_e state;
   redir_state_e state_nxt;
   logic         accept;

   // New jumps are only seen in IDLE; anything arriving while busy is dropped.
   assign accept    = (state == IDLE) && ex_valid && jump_flag;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         redir_pc <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            redir_pc <= jump_target & ALIGN_MASK;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      redir_valid = 1'b0;
      flush_if    = 1'b0;
      flush_id    = 1'b0;
      stall_ex    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = REQ;
         end
         REQ: begin
            redir_valid = 1'b1;
            flush_if    = 1'b1;
            flush_id    = 1'b1;
            stall_ex    = 1'b1;
            if (fetch_ready) state_nxt = DRAIN;
         end
         DRAIN: begin
            flush_if  = 1'b1;
            stall_ex  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef REDIRECT_PERF_EN
   sat_counter #(.W(PERF_W)) u_jump_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (accept),
      .count (jump_count)
   );

   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (stall_ex),
      .count (stall_count)
   );
`else
   assign jump_count  = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: a rule-level cycle model checked every cycle,
// plus literal expectations for the key scenarios. Works with or without REDIRECT_PERF_EN.
module tb_redirect_ctrl;
   import rv_ctrl_pkg::*;

   localparam int XLEN   = 32;
   localparam int PERF_W = 4;
   localparam int PMAX   = (1 << PERF_W) - 1;
`ifdef REDIRECT_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst_n;
   logic              ex_valid, jump_flag, fetch_ready;
   logic [XLEN-1:0]   jump_target;
   logic              redir_valid, flush_if, flush_id, stall_ex;
   logic [XLEN-1:0]   redir_pc;
   logic [PERF_W-1:0] jump_count, stall_count;
   redir_state_e      state_dbg;

   always #5 clk = ~clk;

   redirect_ctrl #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_valid    (ex_valid),
      .jump_flag   (jump_flag),
      .jump_target (jump_target),
      .fetch_ready (fetch_ready),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .flush_if    (flush_if),
      .flush_id    (flush_id),
      .stall_ex    (stall_ex),
      .jump_count  (jump_count),
      .stall_count (stall_count),
      .state_dbg   (state_dbg)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // busy: a redirect is outstanding and not yet taken by fetch.
   // draining: the single post-handshake cleanup cycle.
   bit          m_busy = 1'b0;
   bit          m_draining = 1'b0;
   logic [31:0] m_pc = '0;
   int          m_jumps = 0;
   int          m_stalls = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_draining = 1'b0; m_pc = '0; m_jumps = 0; m_stalls = 0;
      end else begin
         if (m_busy || m_draining) m_stalls = (m_stalls < PMAX) ? m_stalls + 1 : PMAX;
         if (m_draining) begin
            m_draining = 1'b0;
         end else if (m_busy) begin
            if (fetch_ready) begin
               m_busy = 1'b0;
               m_draining = 1'b1;
            end
         end else if (ex_valid && jump_flag) begin
            m_busy = 1'b1;
            m_pc = jump_target - (jump_target % 2);
            m_jumps = (m_jumps < PMAX) ? m_jumps + 1 : PMAX;
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_redir_valid", redir_valid, m_busy);
         chk("m_flush_if", flush_if, m_busy || m_draining);
         chk("m_flush_id", flush_id, m_busy);
         chk("m_stall_ex", stall_ex, m_busy || m_draining);
         chk("m_redir_pc", redir_pc, m_pc);
         chk("m_jump_count", jump_count, PERF ? m_jumps : 0);
         chk("m_stall_count", stall_count, PERF ? m_stalls : 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; jump_flag = 1'b0; fetch_ready = 1'b0; jump_target = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cmp_en = 1'b1;
   endtask

   task automatic drive_jump(input logic [31:0] tgt, input logic ready);
      ex_valid = 1'b1; jump_flag = 1'b1; jump_target = tgt; fetch_ready = ready;
   endtask

   task automatic drop_jump();
      ex_valid = 1'b0; jump_flag = 1'b0;
   endtask

   task automatic chk_outs(input string tag, input logic rv, input logic fi,
                           input logic fd, input logic st);
      chk({tag, "_redir_valid"}, redir_valid, rv);
      chk({tag, "_flush_if"}, flush_if, fi);
      chk({tag, "_flush_id"}, flush_id, fd);
      chk({tag, "_stall_ex"}, stall_ex, st);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      idle_inputs();
      rst_n = 1'b0;
      cyc(2);
      do_reset();
      chk_outs("reset", 0, 0, 0, 0);
      chk("reset_pc", redir_pc, 32'h0);
      chk("reset_jc", jump_count, 0);

      // jump_flag without ex_valid is ignored
      jump_flag = 1'b1; jump_target = 32'h0000_5554; fetch_ready = 1'b1;
      cyc(1);
      jump_flag = 1'b0;
      chk_outs("novalid", 0, 0, 0, 0);

      // immediate handshake, odd target gets bit 0 cleared
      drive_jump(32'h0000_1003, 1'b1);
      cyc(1);
      drop_jump();
      chk_outs("imm_req", 1, 1, 1, 1);
      chk("imm_req_pc", redir_pc, 32'h0000_1002);
      cyc(1);
      chk_outs("imm_drain", 0, 1, 0, 1);
      cyc(1);
      chk_outs("imm_idle", 0, 0, 0, 0);
      chk("imm_jc", jump_count, PERF ? 1 : 0);
      chk("imm_sc", stall_count, PERF ? 2 : 0);

      // backpressure: four not-ready cycles, then handshake
      do_reset();
      drive_jump(32'h0000_0ABC, 1'b0);
      cyc(1);
      drop_jump();
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid", redir_valid, 1'b1);
         chk("bp_pc", redir_pc, 32'h0000_0ABC);
         cyc(1);
      end
      fetch_ready = 1'b1;
      chk("bp_last_req", redir_valid, 1'b1);
      cyc(1);
      fetch_ready = 1'b0;
      chk_outs("bp_drain", 0, 1, 0, 1);
      cyc(1);
      chk_outs("bp_idle", 0, 0, 0, 0);
      chk("bp_stall_count", stall_count, PERF ? 6 : 0);

      // jumps while busy are dropped
      do_reset();
      drive_jump(32'h0000_1000, 1'b0);
      cyc(1);
      jump_target = 32'h0000_2000;
      cyc(2);
      chk("busy_req_pc", redir_pc, 32'h0000_1000);
      fetch_ready = 1'b1;
      cyc(1);
      fetch_ready = 1'b0;
      chk("busy_drain_pc", redir_pc, 32'h0000_1000);
      drop_jump();
      cyc(1);
      chk_outs("busy_idle", 0, 0, 0, 0);
      chk("busy_jc", jump_count, PERF ? 1 : 0);

      // reset mid-REQ with a jump presented in the reset cycle
      do_reset();
      drive_jump(32'h0000_3000, 1'b0);
      cyc(2);
      rst_n = 1'b0;
      drive_jump(32'h0000_4000, 1'b1);
      cyc(1);
      rst_n = 1'b1;
      drop_jump();
      chk_outs("rst_req", 0, 0, 0, 0);
      chk("rst_req_pc", redir_pc, 32'h0);
      chk("rst_req_jc", jump_count, 0);
      chk("rst_req_sc", stall_count, 0);
      cyc(1);
      chk("rst_req_nojump", redir_valid, 1'b0);

      // reset mid-DRAIN
      drive_jump(32'h0000_0040, 1'b1);
      cyc(2);
      drop_jump();
      chk("pre_rst_drain", flush_if, 1'b1);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk_outs("rst_drain", 0, 0, 0, 0);
      chk("rst_drain_pc", redir_pc, 32'h0);

      // 20 back-to-back accepts: counters pin at all-ones
      do_reset();
      drive_jump(32'h0000_8000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         jump_target = 32'h0000_8000 + 32'(i * 4);
         cyc(3);
      end
      drop_jump();
      cyc(3);
      chk("sat_jc", jump_count, PERF ? 4'hF : 4'h0);
      chk("sat_sc", stall_count, PERF ? 4'hF : 4'h0);
      chk("sat_pc", redir_pc, 32'h0000_804C);
      chk_outs("sat_idle", 0, 0, 0, 0);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
